// File: rtl/pipeline_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// pipeline_pkg : shared encodings for the pipeline hazard controller
// Rev 1.0
// ------------------------------------------------------------------
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO            = 5'd0;
  localparam int         DEFAULT_MEM_LATENCY = 2;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ------------------------------------------------------------------
// sat_counter : up-counter that holds at all-ones instead of wrapping
// Rev 1.0
// ------------------------------------------------------------------
module sat_counter
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Inc,
  output logic [CNT_W-1:0] Count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_count <= '0;
    end else if (Inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign Count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// pipeline_hazard_ctrl : enables, bubbles and flushes for the 5-stage pipe
// Rev 1.0
// ------------------------------------------------------------------
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
  parameter int CNT_W       = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       IF_ID_Rs,
  input  logic [4:0]       IF_ID_Rt,
  input  logic             IF_ID_UsesRt,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rt,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             EX_MEM_Redirect,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Flush,
  output logic             MemAck,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int                 c_cnt_w   = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [c_cnt_w-1:0] c_lat_m1  = c_cnt_w'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);
  localparam bit                 c_has_lat = (MEM_LATENCY > 0);

  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic               w_mem_req, w_start, w_freeze, w_redirect, w_load_use;
  logic               w_stall_inc, w_flush_inc;

  assign w_mem_req  = EX_MEM_MemRead | EX_MEM_MemWrite;
  // A redirect and a memory request cannot legally coexist; the redirect wins.
  assign w_start    = c_has_lat && (r_state == ST_RUN) && w_mem_req && !EX_MEM_Redirect;
  assign w_freeze   = w_start || (r_state == ST_WAIT);
  assign w_redirect = EX_MEM_Redirect && (r_state != ST_WAIT);
  assign w_load_use = !w_freeze && !w_redirect && ID_EX_MemRead &&
                      (ID_EX_Rt != REG_ZERO) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    PC_Write     = 1'b1;
    IF_ID_Write  = 1'b1;
    ID_EX_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    MEM_WB_Write = 1'b1;
    ID_EX_Bubble = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    EX_MEM_Flush = 1'b0;
    MemAck       = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (w_start) begin
          w_cnt_nxt   = c_lat_m1;
          w_state_nxt = (MEM_LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - c_cnt_w'(1);
        if (r_cnt == c_cnt_w'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase

    // While in reset the datapath must keep flowing regardless of inputs.
    if (Rst) begin
      MemAck = (r_state == ST_DONE);
      if (w_freeze) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Write  = 1'b0;
        EX_MEM_Write = 1'b0;
        MEM_WB_Write = 1'b0;
      end else if (w_redirect) begin
        IF_ID_Flush  = 1'b1;
        ID_EX_Flush  = 1'b1;
        EX_MEM_Flush = 1'b1;
      end else if (w_load_use) begin
        PC_Write     = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
      end
    end
  end

  assign w_stall_inc = Rst && (w_freeze || w_load_use);
  assign w_flush_inc = Rst && w_redirect;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .Inc   (w_stall_inc),
    .Count (StallCycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .Inc   (w_flush_inc),
    .Count (FlushCount)
  );

endmodule
`default_nettype wire
